// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, access sizes and
// read/write direction codes.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACC_IF = 2'b01,
      ACC_D  = 2'b10
   } state_t;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_align_check.sv
// Flags data accesses with an illegal size code or an address that is not
// naturally aligned to the access size.
module mem_align_check
   import mem_port_arbiter_pkg::*;
(
   input  logic [7:0] addr,
   input  logic [1:0] size,
   output logic       misaligned
);

   always_comb begin
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = addr[0];
         SZ_WORD: misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port byte-addressed RAM,
// data-priority with a bounded starvation limit for fetch.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [7:0]  if_addr,
   output logic        if_gnt,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [1:0]  d_size,
   input  logic [7:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_err,
   output logic        ram_en,
   output logic        ram_rw,
   output logic [7:0]  ram_addr,
   output logic [1:0]  ram_size,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic          err_q;
   logic          misaligned;
   logic          pick_if;

   mem_align_check u_align (
      .addr       (d_addr),
      .size       (d_size),
      .misaligned (misaligned)
   );

   always_comb begin
      next_state = state;
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      pick_if    = if_req && (!d_req || (cnt == LIMIT));
      case (state)
         IDLE: begin
            // Grants are combinational, so they must be masked while reset is high.
            if (!reset) begin
               if (pick_if) begin
                  if_gnt     = 1'b1;
                  next_state = ACC_IF;
               end else if (d_req) begin
                  d_gnt      = 1'b1;
                  next_state = ACC_D;
               end
            end
         end
         ACC_IF:  next_state = IDLE;
         ACC_D:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Gating on reset drops the strobe immediately, before the async clear settles.
   assign ram_en = !reset && ((state == ACC_IF) || ((state == ACC_D) && !err_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         err_q    <= 1'b0;
         ram_rw   <= RW_READ;
         ram_addr <= '0;
         ram_size <= '0;
         ram_din  <= '0;
         if_rdata <= '0;
         if_valid <= 1'b0;
         d_rdata  <= '0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
      end else begin
         state    <= next_state;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;

         if (if_gnt) begin
            cnt      <= '0;
            err_q    <= 1'b0;
            ram_rw   <= RW_READ;
            ram_addr <= if_addr;
            ram_size <= SZ_WORD;
         end else if (d_gnt) begin
            if (if_req && (cnt != LIMIT)) begin
               cnt <= cnt + CW'(1);
            end
            err_q    <= misaligned;
            ram_rw   <= d_rw;
            ram_addr <= d_addr;
            ram_size <= d_size;
            ram_din  <= d_wdata;
         end

         case (state)
            ACC_IF: begin
               if_rdata <= ram_dout;
               if_valid <= 1'b1;
            end
            ACC_D: begin
               d_valid <= 1'b1;
               if (err_q) begin
                  d_err   <= 1'b1;
                  d_rdata <= '0;
               end else if (ram_rw == RW_READ) begin
                  d_rdata <= ram_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian 256x8 RAM model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_rw;
   logic [1:0]  d_size;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_err;
   logic        ram_en;
   logic        ram_rw;
   logic [7:0]  ram_addr;
   logic [1:0]  ram_size;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
      .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_size(ram_size),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   logic [7:0] mem [256];

   always_comb begin
      case (ram_size)
         SZ_BYTE: ram_dout = {24'h0, mem[ram_addr]};
         SZ_HALF: ram_dout = {16'h0, mem[ram_addr], mem[ram_addr + 8'd1]};
         default: ram_dout = {mem[ram_addr], mem[ram_addr + 8'd1],
                              mem[ram_addr + 8'd2], mem[ram_addr + 8'd3]};
      endcase
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10] <= 8'h01;
         mem[8'h11] <= 8'h02;
         mem[8'h12] <= 8'h03;
         mem[8'h13] <= 8'h04;
      end else if (ram_en && ram_rw) begin
         case (ram_size)
            SZ_BYTE: mem[ram_addr] <= ram_din[7:0];
            SZ_HALF: begin
               mem[ram_addr]        <= ram_din[15:8];
               mem[ram_addr + 8'd1] <= ram_din[7:0];
            end
            default: begin
               mem[ram_addr]        <= ram_din[31:24];
               mem[ram_addr + 8'd1] <= ram_din[23:16];
               mem[ram_addr + 8'd2] <= ram_din[15:8];
               mem[ram_addr + 8'd3] <= ram_din[7:0];
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fetch;
      logic        rw;
      logic [1:0]  size;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        exp_en;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   // One isolated transaction: grant at N, RAM access at N+1, response at N+2.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      if_req  = v.fetch;
      if_addr = v.addr;
      d_req   = !v.fetch;
      d_rw    = v.rw;
      d_size  = v.size;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      #1;
      chk("if_gnt", {31'h0, if_gnt}, {31'h0, v.fetch});
      chk("d_gnt", {31'h0, d_gnt}, {31'h0, !v.fetch});
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      chk("acc_ram_en", {31'h0, ram_en}, {31'h0, v.exp_en});
      chk("acc_ram_addr", {24'h0, ram_addr}, {24'h0, v.addr});
      chk("acc_ram_size", {30'h0, ram_size}, {30'h0, (v.fetch ? SZ_WORD : v.size)});
      chk("acc_ram_rw", {31'h0, ram_rw}, {31'h0, (v.fetch ? RW_READ : v.rw)});
      if (!v.fetch && v.rw) chk("acc_ram_din", ram_din, v.wdata);
      chk("acc_no_valid", {30'h0, if_valid, d_valid}, 32'h0);
      @(posedge clk); #1;
      chk("rsp_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rsp_addr_held", {24'h0, ram_addr}, {24'h0, v.addr});
      if (v.fetch) begin
         chk("if_valid", {31'h0, if_valid}, 32'h1);
         chk("if_rdata", if_rdata, v.exp_rdata);
         chk("d_valid_idle", {31'h0, d_valid}, 32'h0);
      end else begin
         chk("d_valid", {31'h0, d_valid}, 32'h1);
         chk("d_rdata", d_rdata, v.exp_rdata);
         chk("d_err", {31'h0, d_err}, {31'h0, v.exp_err});
         chk("if_valid_idle", {31'h0, if_valid}, 32'h0);
      end
   endtask

   // Contention grant: check winner in IDLE, then no grants during the access cycle.
   task automatic grant_cycle(input logic exp_if, input logic exp_d);
      @(negedge clk); #1;
      chk("cont_gnt", {30'h0, if_gnt, d_gnt}, {30'h0, exp_if, exp_d});
      @(posedge clk); #1;
      chk("cont_acc_nogrant", {30'h0, if_gnt, d_gnt}, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, RW_READ,  SZ_WORD, 8'h10, 32'h0,        1'b1, 32'h01020304, 1'b0};
      vecs[1]  = '{1'b0, RW_WRITE, SZ_HALF, 8'h20, 32'h0000BEEF, 1'b1, 32'h00000000, 1'b0};
      vecs[2]  = '{1'b0, RW_READ,  SZ_BYTE, 8'h20, 32'h0,        1'b1, 32'h000000BE, 1'b0};
      vecs[3]  = '{1'b0, RW_READ,  SZ_HALF, 8'h20, 32'h0,        1'b1, 32'h0000BEEF, 1'b0};
      vecs[4]  = '{1'b0, RW_WRITE, SZ_WORD, 8'h40, 32'hDEADBEEF, 1'b1, 32'h0000BEEF, 1'b0};
      vecs[5]  = '{1'b0, RW_READ,  SZ_WORD, 8'h40, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b0, RW_READ,  SZ_BYTE, 8'h43, 32'h0,        1'b1, 32'h000000EF, 1'b0};
      vecs[7]  = '{1'b0, RW_WRITE, SZ_BYTE, 8'h50, 32'h00000077, 1'b1, 32'h000000EF, 1'b0};
      vecs[8]  = '{1'b0, RW_READ,  SZ_BYTE, 8'h50, 32'h0,        1'b1, 32'h00000077, 1'b0};
      vecs[9]  = '{1'b0, RW_READ,  SZ_WORD, 8'h02, 32'h0,        1'b0, 32'h00000000, 1'b1};
      vecs[10] = '{1'b0, RW_WRITE, SZ_HALF, 8'h21, 32'h00001234, 1'b0, 32'h00000000, 1'b1};
      vecs[11] = '{1'b0, RW_READ,  2'b11,   8'h00, 32'h0,        1'b0, 32'h00000000, 1'b1};
      vecs[12] = '{1'b0, RW_WRITE, SZ_WORD, 8'hFC, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b0};
      vecs[13] = '{1'b0, RW_READ,  SZ_WORD, 8'hFC, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
      vecs[14] = '{1'b1, RW_READ,  SZ_WORD, 8'h40, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      vecs[15] = '{1'b0, RW_READ,  SZ_BYTE, 8'h21, 32'h0,        1'b1, 32'h000000EF, 1'b0};

      reset   = 1'b1;
      if_req  = 1'b1;
      if_addr = 8'h10;
      d_req   = 1'b1;
      d_rw    = RW_WRITE;
      d_size  = SZ_WORD;
      d_addr  = 8'h10;
      d_wdata = 32'hFFFFFFFF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnts", {30'h0, if_gnt, d_gnt}, 32'h0);
      chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rst_valids_err", {29'h0, if_valid, d_valid, d_err}, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_ram_fields", {21'h0, ram_rw, ram_addr, ram_size}, 32'h0);
      chk("rst_ram_din", ram_din, 32'h0);
      @(negedge clk);
      if_req = 1'b0;
      d_req  = 1'b0;
      reset  = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) run_vec(vecs[i]);

      if_req  = 1'b1;
      if_addr = 8'h40;
      d_req   = 1'b1;
      d_rw    = RW_READ;
      d_size  = SZ_WORD;
      d_addr  = 8'h10;
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b1, 1'b0);
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b1, 1'b0);

      // Build the counter up to the limit, then reset during the second data access.
      grant_cycle(1'b0, 1'b1);
      @(negedge clk); #1;
      chk("pre_rst_d_gnt", {31'h0, d_gnt}, 32'h1);
      @(posedge clk); #1;
      chk("pre_rst_ram_en", {31'h0, ram_en}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_async_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rst_async_gnts", {30'h0, if_gnt, d_gnt}, 32'h0);
      if_req = 1'b0;
      d_req  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_valid", {30'h0, if_valid, d_valid}, 32'h0);
      end

      if_req = 1'b1;
      d_req  = 1'b1;
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b0, 1'b1);
      grant_cycle(1'b1, 1'b0);
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
